// File: rtl/fasm_drain_if.sv
// rtl/fasm_drain_if.sv - upstream FIFO read port and downstream strobe/ack port of fasm_drain
`timescale 1ns/1ps
interface fasm_drain_if #(
  parameter int DW = 32
);
  logic [DW-1:0] fif_dat_i;
  logic          fif_rok_i;
  logic          fif_rde_o;
  logic [DW-1:0] dat_o;
  logic          stb_o;
  logic          ack_i;
  logic          lst_o;
  logic [1:0]    cnt_o;

  modport slave (
    input  fif_dat_i,
    input  fif_rok_i,
    input  ack_i,
    output fif_rde_o,
    output dat_o,
    output stb_o,
    output lst_o,
    output cnt_o
  );

  modport master (
    output fif_dat_i,
    output fif_rok_i,
    output ack_i,
    input  fif_rde_o,
    input  dat_o,
    input  stb_o,
    input  lst_o,
    input  cnt_o
  );
endinterface

// File: rtl/fasm_drain.sv
// rtl/fasm_drain.sv - two-entry FIFO drain stage (head + skid); packet beat counter under FASM_DRAIN_PKT_EN
`timescale 1ns/1ps
module fasm_drain #(
  parameter int DW  = 32,
  parameter int LEN = 8
) (
  input logic         clk_i,
  input logic         rst_i,
  input logic         clr_i,
  input logic         ena_i,
  fasm_drain_if.slave bus
);

  if (LEN < 1 || LEN > 256) begin : g_len_check
    $error("fasm_drain: LEN must be within 1..256");
  end

  logic [1:0]    cnt_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] skid_q;
  logic          pop;
  logic          xfer;
  logic          stb;

  // stb is derived from occupancy only, so the consumer never sees a
  // combinational loop through ack_i.
  assign stb = (cnt_q != 2'd0);

  // Pop decision depends only on registered occupancy, never on ack_i; the
  // skid entry absorbs the word popped in the same cycle the consumer stalls.
  assign pop  = ~rst_i & ena_i & ~clr_i & bus.fif_rok_i & (cnt_q < 2'd2);
  assign xfer = ena_i & ~clr_i & stb & bus.ack_i;

  assign bus.fif_rde_o = pop;
  assign bus.dat_o     = head_q;
  assign bus.stb_o     = stb;
  assign bus.cnt_o     = cnt_q;

  // Queue occupancy and head/skid data movement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else if (clr_i) begin
      cnt_q <= 2'd0;
    end else if (ena_i) begin
      unique case (cnt_q)
        2'd0: begin
          if (pop) begin
            head_q <= bus.fif_dat_i;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && !xfer) begin
            skid_q <= bus.fif_dat_i;
            cnt_q  <= 2'd2;
          end else if (pop && xfer) begin
            head_q <= bus.fif_dat_i;
          end else if (xfer) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          if (xfer) begin
            head_q <= skid_q;
            cnt_q  <= 2'd1;
          end
        end
        default: begin
          cnt_q <= 2'd0;
        end
      endcase
    end
  end

`ifdef FASM_DRAIN_PKT_EN
  localparam logic [7:0] LAST_BEAT = 8'(LEN - 1);

  logic [7:0] beat_q;

  // Beat position within the current packet; advances on every accepted word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= 8'd0;
    end else if (clr_i) begin
      beat_q <= 8'd0;
    end else if (xfer) begin
      if (beat_q == LAST_BEAT) begin
        beat_q <= 8'd0;
      end else begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  assign bus.lst_o = stb & (beat_q == LAST_BEAT);
`else
  assign bus.lst_o = 1'b0;
`endif

endmodule
